// File: rtl/tcpc_phy_tx_arbiter.sv
// PHY transmit-path arbiter: Hard Reset > GoodCRC > message, with a transfer
// watchdog, an optional inter-frame gap and Hard Reset pre-emption of messages.
module tcpc_phy_tx_arbiter #(
    parameter int unsigned TX_TIMEOUT = 1024,
    parameter int unsigned IFG_CYCLES = 4
) (
    input  logic        clk,
    input  logic        hard_reset_n,
    input  logic        gcrc_req,
    input  logic [15:0] gcrc_hdr,
    output logic        GoodCRC_Transmission_Complete,
    input  logic        msg_req,
    input  logic [2:0]  msg_sop,
    input  logic [15:0] msg_hdr,
    output logic        msg_done,
    output logic        msg_failed,
    output logic        msg_discarded,
    input  logic        hr_req,
    output logic        hr_done,
    input  logic        phy_rx_busy,
    output logic        phy_tx_start,
    output logic [1:0]  phy_tx_kind,
    output logic [2:0]  phy_tx_sop,
    output logic [15:0] phy_tx_hdr,
    output logic        phy_tx_abort,
    input  logic        phy_tx_done,
    input  logic        phy_tx_err
);

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StGap} state_e;

    localparam logic [1:0] KindMsg  = 2'b00;
    localparam logic [1:0] KindGcrc = 2'b01;
    localparam logic [1:0] KindHr   = 2'b10;

    localparam int unsigned CntW = $clog2(TX_TIMEOUT + 1);
    localparam int unsigned GapW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam state_e      StAfter = (IFG_CYCLES == 0) ? StIdle : StGap;

    state_e          state_q, state_d;
    logic [1:0]      kind_q, kind_d;
    logic [2:0]      sop_q, sop_d;
    logic [15:0]     hdr_q, hdr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            hr_q;

    logic gcrc_cmp_q, gcrc_cmp_d;
    logic msg_done_q, msg_done_d;
    logic msg_failed_q, msg_failed_d;
    logic msg_disc_q, msg_disc_d;
    logic hr_done_q, hr_done_d;
    logic abort_q, abort_d;

    logic hr_rise, fin_ok, fin_err, preempt, timeout;

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state_q      <= StIdle;
            kind_q       <= '0;
            sop_q        <= '0;
            hdr_q        <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            hr_q         <= 1'b0;
            gcrc_cmp_q   <= 1'b0;
            msg_done_q   <= 1'b0;
            msg_failed_q <= 1'b0;
            msg_disc_q   <= 1'b0;
            hr_done_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            sop_q        <= sop_d;
            hdr_q        <= hdr_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            hr_q         <= hr_req;
            gcrc_cmp_q   <= gcrc_cmp_d;
            msg_done_q   <= msg_done_d;
            msg_failed_q <= msg_failed_d;
            msg_disc_q   <= msg_disc_d;
            hr_done_q    <= hr_done_d;
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        sop_d   = sop_q;
        hdr_d   = hdr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        hr_rise = hr_req & ~hr_q;
        fin_ok  = 1'b0;
        fin_err = 1'b0;
        preempt = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                gap_d = '0;
                if (hr_req) begin
                    state_d = StStart;
                    kind_d  = KindHr;
                    sop_d   = '0;
                    hdr_d   = '0;
                end else if (gcrc_req) begin
                    state_d = StStart;
                    kind_d  = KindGcrc;
                    sop_d   = '0;
                    hdr_d   = gcrc_hdr;
                end else if (msg_req && !phy_rx_busy) begin
                    state_d = StStart;
                    kind_d  = KindMsg;
                    sop_d   = msg_sop;
                    hdr_d   = msg_hdr;
                end
            end
            StStart: begin
                // Counter tracks cycles since phy_tx_start; the start cycle is cycle 0.
                cnt_d = CntW'(1);
                if (kind_q == KindMsg && hr_rise) begin
                    preempt = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (kind_q == KindMsg && hr_rise) begin
                    preempt = 1'b1;
                    state_d = StIdle;
                end else begin
                    timeout = (cnt_q == CntW'(TX_TIMEOUT - 1));
                    fin_err = phy_tx_err | timeout;
                    fin_ok  = phy_tx_done & ~fin_err;
                    if (fin_ok || fin_err) begin
                        state_d = StAfter;
                        gap_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StGap: begin
                if (hr_req || gap_q == GapW'(IFG_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        phy_tx_start = (state_q == StStart);
        gcrc_cmp_d   = (fin_ok | fin_err) & (kind_q == KindGcrc);
        msg_done_d   = fin_ok & (kind_q == KindMsg);
        msg_failed_d = fin_err & (kind_q == KindMsg);
        hr_done_d    = (fin_ok | fin_err) & (kind_q == KindHr);
        msg_disc_d   = preempt;
        abort_d      = preempt | timeout;
    end

    assign phy_tx_kind                   = kind_q;
    assign phy_tx_sop                    = sop_q;
    assign phy_tx_hdr                    = hdr_q;
    assign phy_tx_abort                  = abort_q;
    assign GoodCRC_Transmission_Complete = gcrc_cmp_q;
    assign msg_done                      = msg_done_q;
    assign msg_failed                    = msg_failed_q;
    assign msg_discarded                 = msg_disc_q;
    assign hr_done                       = hr_done_q;

endmodule

// File: tb/tb_tcpc_phy_tx_arbiter.sv
// Scoreboard bench for tcpc_phy_tx_arbiter: scenarios compute expected output events
// from the arbitration/timing rules; a negedge monitor pops and compares them.
module tb_tcpc_phy_tx_arbiter;

    localparam int unsigned TO  = 16;
    localparam int unsigned IFG = 4;

    localparam logic [1:0] KMsg  = 2'b00;
    localparam logic [1:0] KGcrc = 2'b01;
    localparam logic [1:0] KHr   = 2'b10;

    localparam logic [20:0] MaskAll  = 21'h1F_FFFF;
    localparam logic [20:0] MaskKind = 21'h18_0000;

    // Response codes: 0 done, 1 err, 2 no response (watchdog), 3 done+err together.
    typedef enum int {EvStart, EvAbort, EvMsgDone, EvMsgFail, EvMsgDisc, EvGcrc, EvHrDone} ev_e;
    typedef struct {
        int          cyc;
        ev_e         ev;
        logic [20:0] val;
        logic [20:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   fin = 1'b0;

    logic        clk = 1'b0;
    logic        hard_reset_n;
    logic        gcrc_req, msg_req, hr_req, phy_rx_busy, phy_tx_done, phy_tx_err;
    logic [15:0] gcrc_hdr, msg_hdr;
    logic [2:0]  msg_sop;
    logic        gcrc_cmp, msg_done, msg_failed, msg_discarded, hr_done;
    logic        phy_tx_start, phy_tx_abort;
    logic [1:0]  phy_tx_kind;
    logic [2:0]  phy_tx_sop;
    logic [15:0] phy_tx_hdr;
    logic [20:0] obs;
    logic [27:0] all_out;

    assign obs     = {phy_tx_kind, phy_tx_sop, phy_tx_hdr};
    assign all_out = {phy_tx_start, phy_tx_abort, gcrc_cmp, msg_done, msg_failed,
                      msg_discarded, hr_done, obs};

    tcpc_phy_tx_arbiter #(
        .TX_TIMEOUT(TO),
        .IFG_CYCLES(IFG)
    ) dut (
        .clk                           (clk),
        .hard_reset_n                  (hard_reset_n),
        .gcrc_req                      (gcrc_req),
        .gcrc_hdr                      (gcrc_hdr),
        .GoodCRC_Transmission_Complete (gcrc_cmp),
        .msg_req                       (msg_req),
        .msg_sop                       (msg_sop),
        .msg_hdr                       (msg_hdr),
        .msg_done                      (msg_done),
        .msg_failed                    (msg_failed),
        .msg_discarded                 (msg_discarded),
        .hr_req                        (hr_req),
        .hr_done                       (hr_done),
        .phy_rx_busy                   (phy_rx_busy),
        .phy_tx_start                  (phy_tx_start),
        .phy_tx_kind                   (phy_tx_kind),
        .phy_tx_sop                    (phy_tx_sop),
        .phy_tx_hdr                    (phy_tx_hdr),
        .phy_tx_abort                  (phy_tx_abort),
        .phy_tx_done                   (phy_tx_done),
        .phy_tx_err                    (phy_tx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    task automatic check_ev(input ev_e ev);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected at cycle %0d val %h, want no event", ev.name(), cyc, obs);
        end else begin
            e = exp_q.pop_front();
            if (e.ev != ev || e.cyc != cyc || ((e.val ^ obs) & e.mask) != '0) begin
                miscompares++;
                $display("FAIL %s: got %s@%0d val %h, want %s@%0d val %h", ev.name(), ev.name(),
                         cyc, obs, e.ev.name(), e.cyc, e.val & e.mask);
            end
        end
    endtask

    always @(negedge clk or negedge hard_reset_n) begin
        exp_t e;
        if (!hard_reset_n) begin
            #1;
            vectors++;
            if (all_out != '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %h, want 0", all_out);
            end
        end else if (fin) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL %s: never seen, want @%0d", e.ev.name(), e.cyc);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL %s: missing at cycle %0d, got nothing", e.ev.name(), e.cyc);
            end
            if (phy_tx_start)  check_ev(EvStart);
            if (phy_tx_abort)  check_ev(EvAbort);
            if (msg_done)      check_ev(EvMsgDone);
            if (msg_failed)    check_ev(EvMsgFail);
            if (msg_discarded) check_ev(EvMsgDisc);
            if (gcrc_cmp)      check_ev(EvGcrc);
            if (hr_done)       check_ev(EvHrDone);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input int c, input ev_e ev, input logic [20:0] v, input logic [20:0] m);
        exp_t e;
        e.cyc  = c;
        e.ev   = ev;
        e.val  = v;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    function automatic logic [20:0] mask_of(input logic [1:0] k);
        return (k == KHr) ? MaskKind : MaskAll;
    endfunction

    // Completion events of one transfer; watchdog expiry adds an abort and reports as error.
    task automatic push_end(input logic [1:0] k, input int resp, input int p, input logic [20:0] v);
        ev_e ev;
        if (k == KMsg) ev = (resp == 0) ? EvMsgDone : EvMsgFail;
        else if (k == KGcrc) ev = EvGcrc;
        else ev = EvHrDone;
        if (resp == 2) push(p, EvAbort, v, mask_of(k));
        push(p, ev, v, mask_of(k));
    endtask

    task automatic set_req(input logic [1:0] k, input logic lvl);
        if (k == KMsg) msg_req = lvl;
        else if (k == KGcrc) gcrc_req = lvl;
        else hr_req = lvl;
    endtask

    task automatic pulse_phy(input int resp, input int at);
        wait_until(at);
        phy_tx_done = (resp == 0 || resp == 3);
        phy_tx_err  = (resp == 1 || resp == 3);
        step();
        phy_tx_done = 1'b0;
        phy_tx_err  = 1'b0;
    endtask

    // One requester alone; phy_rx_busy is held for 'busy' cycles (only messages wait on it).
    task automatic single(input logic [1:0] k, input logic [2:0] sop, input logic [15:0] hdr,
                          input int busy, input int resp, input int d);
        int c, s, p;
        logic [20:0] v;
        c = cyc + ((k == KMsg) ? busy : 0);
        s = c + 1;
        p = (resp == 2) ? s + TO : s + d + 1;
        v = {k, (k == KMsg) ? sop : 3'd0, hdr};
        push(s, EvStart, v, mask_of(k));
        push_end(k, resp, p, v);
        msg_sop     = sop;
        msg_hdr     = hdr;
        gcrc_hdr    = hdr;
        phy_rx_busy = (busy > 0);
        set_req(k, 1'b1);
        wait_until((k == KMsg) ? c : s);
        phy_rx_busy = 1'b0;
        if (resp != 2) pulse_phy(resp, s + d);
        wait_until(p + 1);
        set_req(k, 1'b0);
        if ($urandom_range(0, 1) == 1) pulse_phy(0, p + 2);
        wait_until(p + 4);
    endtask

    task automatic gcrc_then_msg(input logic [15:0] ghdr, input logic [2:0] msop,
                                 input logic [15:0] mhdr, input int d1, input int d2);
        int s1, p1, s2, p2;
        s1 = cyc + 1;
        p1 = s1 + d1 + 1;
        s2 = p1 + IFG + 1;
        p2 = s2 + d2 + 1;
        push(s1, EvStart, {KGcrc, 3'd0, ghdr}, MaskAll);
        push(p1, EvGcrc, {KGcrc, 3'd0, ghdr}, MaskAll);
        push(s2, EvStart, {KMsg, msop, mhdr}, MaskAll);
        push(p2, EvMsgDone, {KMsg, msop, mhdr}, MaskAll);
        gcrc_hdr = ghdr;
        msg_sop  = msop;
        msg_hdr  = mhdr;
        gcrc_req = 1'b1;
        msg_req  = 1'b1;
        pulse_phy(0, s1 + d1);
        wait_until(p1 + 1);
        gcrc_req = 1'b0;
        pulse_phy(0, s2 + d2);
        wait_until(p2 + 1);
        msg_req = 1'b0;
        wait_until(p2 + 4);
    endtask

    // Hard Reset raised k cycles after a message starts: abort+discard, then Hard Reset.
    task automatic preempt(input logic [2:0] sop, input logic [15:0] hdr, input int k,
                           input int dh);
        int s, r, h, ph;
        s  = cyc + 1;
        r  = s + k + 1;
        h  = r + 1;
        ph = h + dh + 1;
        push(s, EvStart, {KMsg, sop, hdr}, MaskAll);
        push(r, EvAbort, {KMsg, sop, hdr}, MaskAll);
        push(r, EvMsgDisc, {KMsg, sop, hdr}, MaskAll);
        push(h, EvStart, {KHr, 19'd0}, MaskKind);
        push(ph, EvHrDone, {KHr, 19'd0}, MaskKind);
        msg_sop = sop;
        msg_hdr = hdr;
        msg_req = 1'b1;
        wait_until(s + k);
        hr_req = 1'b1;
        wait_until(h);
        msg_req = 1'b0;
        pulse_phy(0, h + dh);
        wait_until(ph + 1);
        hr_req = 1'b0;
        wait_until(ph + 4);
    endtask

    // Hard Reset raised during a GoodCRC waits for it, then cuts the gap short.
    task automatic hr_waits_gcrc(input logic [15:0] ghdr, input int d, input int k, input int dh);
        int s, pg, h, ph;
        s  = cyc + 1;
        pg = s + d + 1;
        h  = pg + 2;
        ph = h + dh + 1;
        push(s, EvStart, {KGcrc, 3'd0, ghdr}, MaskAll);
        push(pg, EvGcrc, {KGcrc, 3'd0, ghdr}, MaskAll);
        push(h, EvStart, {KHr, 19'd0}, MaskKind);
        push(ph, EvHrDone, {KHr, 19'd0}, MaskKind);
        gcrc_hdr = ghdr;
        gcrc_req = 1'b1;
        wait_until(s + k);
        hr_req = 1'b1;
        pulse_phy(0, s + d);
        wait_until(pg + 1);
        gcrc_req = 1'b0;
        pulse_phy(0, h + dh);
        wait_until(ph + 1);
        hr_req = 1'b0;
        wait_until(ph + 4);
    endtask

    task automatic reset_mid_busy(input logic [15:0] hdr);
        int s;
        s = cyc + 1;
        push(s, EvStart, {KMsg, 3'd0, hdr}, MaskAll);
        msg_sop = 3'd0;
        msg_hdr = hdr;
        msg_req = 1'b1;
        wait_until(s + 3);
        #2;
        hard_reset_n = 1'b0;
        msg_req      = 1'b0;
        phy_tx_done  = 1'b1;
        step();
        phy_tx_done = 1'b0;
        step();
        hard_reset_n = 1'b1;
        wait_until(s + 20);
    endtask

    initial begin
        int t, d;
        logic [15:0] h;
        logic [2:0]  sp;
        hard_reset_n = 1'b0;
        gcrc_req     = 1'b0;
        msg_req      = 1'b0;
        hr_req       = 1'b0;
        phy_rx_busy  = 1'b0;
        phy_tx_done  = 1'b0;
        phy_tx_err   = 1'b0;
        gcrc_hdr     = '0;
        msg_hdr      = '0;
        msg_sop      = '0;
        repeat (3) @(posedge clk);
        #1;
        hard_reset_n = 1'b1;
        step();

        single(KMsg, 3'd0, 16'h1161, 0, 0, 5);
        gcrc_then_msg(16'h0041, 3'd1, 16'h2222, 3, 4);
        single(KMsg, 3'd2, 16'h3333, 50, 0, 2);
        preempt(3'd0, 16'h4444, 4, 3);
        preempt(3'd1, 16'h4545, 0, 2);
        single(KMsg, 3'd0, 16'h5555, 0, 2, 1);
        single(KMsg, 3'd3, 16'h6666, 0, 3, 6);
        single(KGcrc, 3'd5, 16'h7777, 6, 1, 14);
        single(KHr, 3'd0, 16'h0000, 0, 0, 3);
        hr_waits_gcrc(16'h0141, 6, 2, 2);
        reset_mid_busy(16'hBEEF);

        for (int i = 0; i < 40; i++) begin
            t  = int'($urandom_range(0, 4));
            h  = 16'($urandom);
            sp = 3'($urandom);
            d  = int'($urandom_range(1, 14));
            case (t)
                0, 1: single(2'($urandom_range(0, 2)), sp, h,
                             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0,
                             int'($urandom_range(0, 3)), d);
                2: gcrc_then_msg(h, sp, ~h, d, int'($urandom_range(1, 14)));
                3: preempt(sp, h, int'($urandom_range(0, 12)), d);
                default: hr_waits_gcrc(h, d, int'($urandom_range(0, d)),
                                       int'($urandom_range(1, 14)));
            endcase
        end

        step();
        fin = 1'b1;
    end

endmodule
